// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants and the memory-stage state type.
package cpu_pipe_pkg;

  localparam int MEM_RD = 1;
  localparam int MEM_WR = 0;

  localparam int PC_W   = 16;
  localparam int WB_W   = 3;
  localparam int DEST_W = 3;
  localparam int PAD_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Ready-wait counter for the memory stage; timeout marks the edge on which
// the count would reach MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign timeout = en & ~clr & (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: performs loads/stores over a req/ready handshake,
// stalls upstream while an access is in flight, and holds the M/WB register.
module mem_stage_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   PC_plus1_in_M,
  input  logic [WB_W-1:0]   WB_in_M,
  input  logic [1:0]        Memory_in_M,
  input  logic [DATA_W-1:0] ALU_in_M,
  input  logic [DATA_W-1:0] Memory_data_write_in_M,
  input  logic [PAD_W-1:0]  Zero_pad_in_M,
  input  logic [DEST_W-1:0] Dest_in_M,
  input  logic              Valid_in_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Stall_M,
  output logic [PC_W-1:0]   PC_plus1_out_M_WB,
  output logic [WB_W-1:0]   WB_out_M_WB,
  output logic [DATA_W-1:0] Result_out_M_WB,
  output logic [PAD_W-1:0]  Zero_pad_out_M_WB,
  output logic [DEST_W-1:0] Dest_out_M_WB,
  output logic              Valid_out_M_WB,
  output logic              Bus_err
);

  mem_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WB_W-1:0]   wb_q, wb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [PAD_W-1:0]  pad_q, pad_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              valid_q, valid_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              abort_q, abort_d;
  logic              acc, illegal, timeout, in_req;

  assign acc     = Valid_in_M & ((Memory_in_M == 2'b10) | (Memory_in_M == 2'b01));
  assign illegal = Valid_in_M & (Memory_in_M == 2'b11);
  assign in_req  = (state_q == REQ);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (~in_req | mem_ready),
    .en      (in_req),
    .timeout (timeout)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_d        = pc_q;
    wb_d        = wb_q;
    result_d    = result_q;
    pad_d       = pad_q;
    dest_d      = dest_q;
    valid_d     = valid_q;
    bus_err_d   = 1'b0;
    rdata_d     = rdata_q;
    abort_d     = abort_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          mem_req_d   = 1'b1;
          mem_we_d    = Memory_in_M[MEM_WR];
          mem_addr_d  = ALU_in_M[ADDR_W-1:0];
          mem_wdata_d = Memory_data_write_in_M;
          valid_d     = 1'b0;
          state_d     = REQ;
        end else begin
          pc_d      = PC_plus1_in_M;
          wb_d      = WB_in_M;
          result_d  = ALU_in_M;
          pad_d     = Zero_pad_in_M;
          dest_d    = Dest_in_M;
          valid_d   = Valid_in_M & ~illegal;
          bus_err_d = illegal;
        end
      end
      REQ: begin
        // Ready wins over a timeout landing on the same edge.
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (!mem_we_q)
            rdata_d = mem_rdata;
          state_d = DONE;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          abort_d   = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        pc_d      = PC_plus1_in_M;
        wb_d      = WB_in_M;
        result_d  = mem_we_q ? ALU_in_M : rdata_q;
        pad_d     = Zero_pad_in_M;
        dest_d    = Dest_in_M;
        valid_d   = Valid_in_M & ~abort_q;
        bus_err_d = abort_q;
        abort_d   = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pc_q        <= '0;
      wb_q        <= '0;
      result_q    <= '0;
      pad_q       <= '0;
      dest_q      <= '0;
      valid_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      rdata_q     <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_q        <= pc_d;
      wb_q        <= wb_d;
      result_q    <= result_d;
      pad_q       <= pad_d;
      dest_q      <= dest_d;
      valid_q     <= valid_d;
      bus_err_q   <= bus_err_d;
      rdata_q     <= rdata_d;
      abort_q     <= abort_d;
    end
  end

  // Gated by reset so the stall drops the instant reset asserts.
  assign Stall_M = reset & (((state_q == IDLE) & acc) | in_req);

  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign PC_plus1_out_M_WB = pc_q;
  assign WB_out_M_WB       = wb_q;
  assign Result_out_M_WB   = result_q;
  assign Zero_pad_out_M_WB = pad_q;
  assign Dest_out_M_WB     = dest_q;
  assign Valid_out_M_WB    = valid_q;
  assign Bus_err           = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Transaction-level bench for mem_stage_ctrl: each instruction's stall length,
// bus activity and M/WB result are predicted from the stage's rules.
module tb_mem_stage_ctrl;

  localparam int MAXW = 4;

  logic        clk, rst_n;
  logic [15:0] pc_in, alu_in, wd_in, pad_in, rdata;
  logic [2:0]  wb_in, dest_in;
  logic [1:0]  mem_in;
  logic        valid_in, ready;
  logic        mem_req, mem_we, stall, valid_out, bus_err;
  logic [15:0] mem_addr, mem_wdata, pc_out, res_out, pad_out;
  logic [2:0]  wb_out, dest_out;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model of the M/WB register and the captured load data.
  logic [15:0] e_pc, e_res, e_pad, m_rdata;
  logic [2:0]  e_wb, e_dest;
  logic        e_valid, e_err;

  mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(MAXW)) dut (
    .clock(clk), .reset(rst_n),
    .PC_plus1_in_M(pc_in), .WB_in_M(wb_in), .Memory_in_M(mem_in),
    .ALU_in_M(alu_in), .Memory_data_write_in_M(wd_in), .Zero_pad_in_M(pad_in),
    .Dest_in_M(dest_in), .Valid_in_M(valid_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(ready), .mem_rdata(rdata), .Stall_M(stall),
    .PC_plus1_out_M_WB(pc_out), .WB_out_M_WB(wb_out), .Result_out_M_WB(res_out),
    .Zero_pad_out_M_WB(pad_out), .Dest_out_M_WB(dest_out),
    .Valid_out_M_WB(valid_out), .Bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string pfx);
    chk({pfx, "_pc"}, pc_out, e_pc);
    chk({pfx, "_wb"}, wb_out, e_wb);
    chk({pfx, "_res"}, res_out, e_res);
    chk({pfx, "_pad"}, pad_out, e_pad);
    chk({pfx, "_dest"}, dest_out, e_dest);
    chk({pfx, "_valid"}, valid_out, e_valid);
    chk({pfx, "_buserr"}, bus_err, e_err);
  endtask

  task automatic model_clear();
    e_pc = '0; e_wb = '0; e_res = '0; e_pad = '0; e_dest = '0;
    e_valid = 1'b0; e_err = 1'b0; m_rdata = '0;
  endtask

  // lat = REQ cycle (1-based) on which ready is returned; outside 1..MAXW means never.
  task automatic run_instr(input logic [1:0] mem, input logic valid, input logic [15:0] alu,
                           input logic [15:0] wd, input int lat, input logic [15:0] rd);
    logic acc, illegal, abort, is_load;
    int eff, s;
    acc     = valid && (mem == 2'b01 || mem == 2'b10);
    illegal = valid && (mem == 2'b11);
    is_load = (mem == 2'b10);
    abort   = !(lat >= 1 && lat <= MAXW);
    eff     = abort ? MAXW : lat;
    s       = acc ? 1 + eff : 0;
    pc_in = 16'($urandom); wb_in = 3'($urandom); dest_in = 3'($urandom); pad_in = 16'($urandom);
    mem_in = mem; valid_in = valid; alu_in = alu; wd_in = wd;
    ready = 1'($urandom); rdata = 16'($urandom);
    for (int c = 0; c <= s; c++) begin
      @(negedge clk);
      chk("stall", stall, (c < s));
      if (c >= 1 && c < s) begin
        chk("req_high", mem_req, 1);
        chk("req_we", mem_we, !is_load);
        chk("req_addr", mem_addr, alu);
        chk("req_wdata", mem_wdata, wd);
        chk("req_bubble", valid_out, 0);
        chk("req_res_hold", res_out, e_res);
        chk("req_buserr", bus_err, 0);
      end else begin
        chk("req_low", mem_req, 0);
      end
      @(posedge clk); #1;
      if (c + 1 >= 1 && c + 1 < s) begin
        ready = (c + 1 == lat);
        rdata = (c + 1 == lat) ? rd : 16'($urandom);
      end else begin
        ready = 1'($urandom);
        rdata = 16'($urandom);
      end
    end
    e_pc = pc_in; e_wb = wb_in; e_pad = pad_in; e_dest = dest_in;
    if (acc) begin
      if (is_load && !abort) m_rdata = rd;
      e_res   = is_load ? m_rdata : alu;
      e_valid = valid && !abort;
      e_err   = abort;
    end else begin
      e_res   = alu;
      e_valid = valid && !illegal;
      e_err   = illegal;
    end
    chk_wb("out");
    $display("txn %0d mem=%b valid=%b lat=%0d stall_cycles=%0d res=%h valid_out=%b bus_err=%b",
             txn, mem, valid, lat, s, res_out, valid_out, bus_err);
    txn++;
  endtask

  task automatic zero_inputs();
    pc_in = '0; wb_in = '0; mem_in = '0; alu_in = '0; wd_in = '0;
    pad_in = '0; dest_in = '0; valid_in = 1'b0; ready = 1'b0; rdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    zero_inputs();
    model_clear();
    #3;
    chk_wb("rst");
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(2'b00, 1'b1, 16'h1234, 16'h0000, 0, 16'h0000);  // ALU pass-through
    chk("alu_dest_known", dest_out, e_dest);
    run_instr(2'b10, 1'b1, 16'h0040, 16'h0000, 2, 16'hBEEF);  // load, ready on 2nd REQ cycle
    chk("load_res", res_out, 16'hBEEF);
    run_instr(2'b00, 1'b0, 16'h5555, 16'h0000, 0, 16'h0000);  // bubble right after: valid pulse ends
    run_instr(2'b01, 1'b1, 16'h0010, 16'hA5A5, 1, 16'hFFFF);  // store, ready first cycle
    chk("store_res", res_out, 16'h0010);
    run_instr(2'b10, 1'b1, 16'h0020, 16'h0000, 0, 16'h0000);  // load timeout
    chk("timeout_err", bus_err, 1);
    run_instr(2'b00, 1'b1, 16'h0001, 16'h0000, 0, 16'h0000);  // bus_err is a single pulse
    run_instr(2'b11, 1'b1, 16'h0033, 16'h0000, 1, 16'h0000);  // illegal code
    run_instr(2'b10, 1'b0, 16'h0044, 16'h0000, 1, 16'h0000);  // invalid load is a bubble
    run_instr(2'b10, 1'b1, 16'h0050, 16'h0000, MAXW, 16'h1357); // ready on the last allowed cycle
    run_instr(2'b10, 1'b1, 16'h0052, 16'h0000, 1, 16'h2468);  // back-to-back load

    // Reset between edges while a load is waiting.
    mem_in = 2'b10; valid_in = 1'b1; alu_in = 16'h0077; ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("midrst_req", mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_addr", mem_addr, 0);
    chk_wb("midrst");
    zero_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(2'b10, 1'b1, 16'h0040, 16'h0000, 1, 16'hC0DE);
    chk("post_rst_load", res_out, 16'hC0DE);

    for (int i = 0; i < 40; i++) begin
      run_instr(2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0), 16'($urandom),
                16'($urandom), $urandom_range(0, MAXW + 1), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller and M/WB pipeline register. It is the consumer end of the EX/M register interface.
- It takes the EX/M outputs, performs the data-memory load or store over a req/ready handshake, and stalls upstream while the access is in flight.
- It registers the stage results toward write-back.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- DATA_W, 16, data and result width.
- ADDR_W, 16, memory address width, taken from the ALU result.
- MAX_WAIT, 255, ready-wait cycles before the access is aborted.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-low reset.
- PC_plus1_in_M  in  16  PC+1 from EX/M.
- WB_in_M  in  3  write-back control from EX/M.
- Memory_in_M  in  2  bit1 = read, bit0 = write.
- ALU_in_M  in  DATA_W  ALU result; serves as the address for loads and stores.
- Memory_data_write_in_M  in  DATA_W  store data.
- Zero_pad_in_M  in  16  zero-padded immediate.
- Dest_in_M  in  3  destination register.
- Valid_in_M  in  1  instruction valid.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  store data.
- mem_ready  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  load data.
- Stall_M  out  1  holds EX/M and all earlier stages.
- PC_plus1_out_M_WB  out  16
- WB_out_M_WB  out  3
- Result_out_M_WB  out  DATA_W  load data or ALU result.
- Zero_pad_out_M_WB  out  16
- Dest_out_M_WB  out  3
- Valid_out_M_WB  out  1
- Bus_err  out  1  one-cycle pulse on timeout or an illegal Memory code.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - Every *_M_WB output = 0; Bus_err = 0.
  - Stall_M = 0.
  - A reset asserted mid-access drops mem_req immediately; the transaction is abandoned.
- Access decode:
  - acc = Valid_in_M & (Memory_in_M == 2'b10 | Memory_in_M == 2'b01).
  - Memory_in_M == 2'b11 with Valid_in_M = 1 is illegal: treated as no access, Valid_out_M_WB=0 for that slot, Bus_err pulses 1 on the same edge.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If !acc: on each edge the M/WB outputs load from the inputs with Result = ALU_in_M. This includes Valid=0 bubbles. Stall_M = 0.
  - If acc: Stall_M = 1 (combinational). At the edge, load mem_req=1, mem_we=Memory_in_M[0], mem_addr=ALU_in_M[ADDR_W-1:0], mem_wdata=Memory_data_write_in_M. Next state REQ. M/WB outputs keep their value except Valid_out_M_WB, which becomes 0 (bubble).
- REQ:
  - Stall_M = 1; mem_* are held stable; the counter increments each cycle.
  - If mem_ready=1 at an edge: for a load, capture mem_rdata into the internal rdata register. Drop mem_req, clear the counter, go to DONE.
  - If the counter reaches MAX_WAIT with no ready: drop mem_req, set the abort flag, go to DONE.
  - mem_ready is sampled only in REQ and ignored in IDLE and DONE.
- DONE:
  - Stall_M = 0, so EX/M advances on this edge. EX/M inputs still present the same instruction during DONE.
  - At the edge, M/WB outputs load from the inputs. Result = captured rdata for a load, ALU_in_M for a store.
  - Valid_out_M_WB = Valid_in_M & !abort. On abort, Bus_err pulses 1 on the same edge.
  - Next state IDLE; the abort flag clears.
- Timing:
  - Load/store latency: issue edge + N ready-wait cycles + DONE edge. With ready on the first REQ cycle, the result appears 3 edges after the instruction arrives.
  - Back-to-back memory ops: each goes IDLE→REQ→DONE; the second is decoded in the IDLE cycle after DONE.
- Stall_M is purely combinational from state and inputs: IDLE&acc | REQ.
- Stores do not modify the register result path. WB_out_M_WB passes through; write-back ignores Result when WB disables the write.

Decomposition:
- Package cpu_pipe_pkg holds:
  - MEM_RD=1 and MEM_WR=0 bit indices;
  - the state enum (IDLE/REQ/DONE);
  - the WB/Dest/PC width constants.
- Sub-module mem_wait_timer: counter with clear/enable inputs and a timeout output at MAX_WAIT, same clock and reset.

Test Plan:
- ALU op with Memory=00, ALU_in=0x1234, Dest=3, Valid=1 → next edge Result_out=0x1234, Dest_out=3, Valid_out=1; Stall_M stays 0.
- Load from addr 0x0040, mem_ready asserted 2 cycles after mem_req with rdata=0xBEEF → Stall_M high 3 cycles, mem_we=0, Result_out=0xBEEF, Valid_out=1 for one cycle, no duplicate request.
- Store with ALU_in=0x0010, data 0xA5A5, ready on the first REQ cycle → mem_we=1, mem_addr=0x0010, mem_wdata=0xA5A5, Result_out=0x0010, Valid_out=1.
- Load with mem_ready held 0, MAX_WAIT=4 → mem_req drops after 4 REQ cycles, Bus_err pulses once, Valid_out=0, FSM returns to IDLE.
- Memory=11 with Valid=1 → no mem_req, Bus_err=1 for one cycle, Valid_out=0, no stall.
- reset driven low during REQ, between clock edges → mem_req, Stall_M and all outputs go to 0 immediately; after release a fresh load completes normally.
